// File: rtl/tone_pkg.sv
// Shared tone definitions: the 2-bit tone codes used by both the buzzer generator
// and the detector, default period limits for a 50 MHz clock, and the detector FSM encoding.
package tone_pkg;

    localparam logic [1:0] TONE_261 = 2'b00;
    localparam logic [1:0] TONE_329 = 2'b01;
    localparam logic [1:0] TONE_415 = 2'b10;
    localparam logic [1:0] TONE_523 = 2'b11;

    // Period limits in 50 MHz cycles; LIM4 doubles as the silence timeout.
    localparam int LIM0_DEF = 88_000;
    localparam int LIM1_DEF = 108_000;
    localparam int LIM2_DEF = 135_000;
    localparam int LIM3_DEF = 171_000;
    localparam int LIM4_DEF = 210_000;

    typedef enum logic {
        ST_ARM     = 1'b0,
        ST_MEASURE = 1'b1
    } state_t;

endpackage

// File: rtl/sync_edge.sv
// Two-flop synchronizer for an asynchronous input followed by a registered
// rising-edge pulse (one clk cycle wide).
module sync_edge (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic rise
);

    logic sync_p0;
    logic sync_p1;
    logic edge_p2;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_p0 <= 1'b0;
            sync_p1 <= 1'b0;
            edge_p2 <= 1'b0;
            rise    <= 1'b0;
        end else begin
            sync_p0 <= din;
            sync_p1 <= sync_p0;
            // edge detection stage
            edge_p2 <= sync_p1;
            rise    <= sync_p1 & ~edge_p2;
        end
    end

endmodule

// File: rtl/tone_detector.sv
// Measures the period of an asynchronous square wave and decodes it to a locked
// 2-bit tone code once MATCH_N consecutive periods fall in the same band.
module tone_detector
    import tone_pkg::*;
#(
    parameter int CLK_HZ  = 50_000_000,
    parameter int CNT_W   = 18,
    parameter int LIM0    = LIM0_DEF,
    parameter int LIM1    = LIM1_DEF,
    parameter int LIM2    = LIM2_DEF,
    parameter int LIM3    = LIM3_DEF,
    parameter int LIM4    = LIM4_DEF,
    parameter int MATCH_N = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tone_in,
    output logic [1:0] tone_code,
    output logic       tone_valid,
    output logic       tone_change
);

    if (CLK_HZ < 1 || MATCH_N < 1 || (1 << CNT_W) <= LIM4) begin : g_param_check
        $error("tone_detector: CNT_W too narrow for LIM4, or bad CLK_HZ/MATCH_N");
    end

    localparam int MCNT_W = $clog2(MATCH_N + 1);

    localparam logic [CNT_W-1:0]  L0      = CNT_W'(LIM0);
    localparam logic [CNT_W-1:0]  L1      = CNT_W'(LIM1);
    localparam logic [CNT_W-1:0]  L2      = CNT_W'(LIM2);
    localparam logic [CNT_W-1:0]  L3      = CNT_W'(LIM3);
    localparam logic [CNT_W-1:0]  L4      = CNT_W'(LIM4);
    localparam logic [CNT_W-1:0]  LAST    = CNT_W'(LIM4 - 1);
    localparam logic [MCNT_W-1:0] MATCH_C = MCNT_W'(MATCH_N);

    // Returns {in_band, code}
    function automatic logic [2:0] classify(input logic [CNT_W-1:0] p);
        if (p >= L0 && p <= L1) return {1'b1, TONE_523};
        if (p >  L1 && p <= L2) return {1'b1, TONE_415};
        if (p >  L2 && p <= L3) return {1'b1, TONE_329};
        if (p >  L3 && p <  L4) return {1'b1, TONE_261};
        return 3'b000;
    endfunction

    function automatic logic [MCNT_W-1:0] sat_inc(input logic [MCNT_W-1:0] v);
        return (v >= MATCH_C) ? MATCH_C : v + 1'b1;
    endfunction

    logic               rise;
    state_t             state;
    logic [CNT_W-1:0]   count;
    logic [1:0]         cand;
    logic [MCNT_W-1:0]  mcnt;

    logic [CNT_W-1:0]   period;
    logic [2:0]         cls;
    logic               in_band;
    logic [1:0]         next_cand;
    logic [MCNT_W-1:0]  next_mcnt;
    logic               load;

    sync_edge u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .din   (tone_in),
        .rise  (rise)
    );

    // Lock decision for the period that ends on the current rise
    always_comb begin
        period    = count + 1'b1;
        cls       = classify(period);
        in_band   = cls[2];
        next_cand = cand;
        next_mcnt = '0;
        if (in_band) begin
            if (cls[1:0] == cand) begin
                next_mcnt = sat_inc(mcnt);
            end else begin
                next_cand = cls[1:0];
                next_mcnt = MCNT_W'(1);
            end
        end
        load = in_band && (next_mcnt == MATCH_C) && (!tone_valid || next_cand != tone_code);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= ST_ARM;
            count       <= '0;
            cand        <= TONE_261;
            mcnt        <= '0;
            tone_code   <= TONE_261;
            tone_valid  <= 1'b0;
            tone_change <= 1'b0;
        end else begin
            tone_change <= 1'b0;
            case (state)
                ST_ARM: begin
                    count <= '0;
                    if (rise) state <= ST_MEASURE;
                end
                ST_MEASURE: begin
                    if (rise) begin
                        count <= '0;
                        cand  <= next_cand;
                        mcnt  <= next_mcnt;
                        if (!in_band) begin
                            tone_valid <= 1'b0;
                        end else if (load) begin
                            tone_code   <= next_cand;
                            tone_valid  <= 1'b1;
                            tone_change <= 1'b1;
                        end
                    end else if (count == LAST) begin
                        // silence: drop the lock and wait for a fresh arming edge
                        count      <= L4;
                        state      <= ST_ARM;
                        tone_valid <= 1'b0;
                        mcnt       <= '0;
                    end else begin
                        count <= count + 1'b1;
                    end
                end
                default: state <= ST_ARM;
            endcase
        end
    end

endmodule

// File: tb/tb_tone_detector.sv
// Bench for tone_detector with period limits scaled down by 1000 so that whole
// lock/change/timeout scenarios fit in a short simulation.
module tb_tone_detector;
    import tone_pkg::*;

    localparam int LIM0    = 88;
    localparam int LIM1    = 108;
    localparam int LIM2    = 135;
    localparam int LIM3    = 171;
    localparam int LIM4    = 210;
    localparam int MATCH_N = 3;
    // Negedges from driving a pin edge until the updated outputs are visible
    localparam int OUT_LAT = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       tone_in = 1'b0;
    logic [1:0] tone_code;
    logic       tone_valid;
    logic       tone_change;

    int tests = 0;
    int fails = 0;
    int cyc = 0;

    // Reference model state
    int hist[$];
    int m_valid = 0;
    int m_code = 0;
    int exp_chg_now = 0;
    int last_edge = -1_000_000;
    int win_chg = 0;
    int chg_pos = 0;

    typedef struct {
        int   period;
        int   reps;
        int   exp_valid;
        int   exp_code;
    } vec_t;

    vec_t vecs[13];

    tone_detector #(
        .CLK_HZ  (50_000),
        .CNT_W   (8),
        .LIM0    (LIM0),
        .LIM1    (LIM1),
        .LIM2    (LIM2),
        .LIM3    (LIM3),
        .LIM4    (LIM4),
        .MATCH_N (MATCH_N)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .tone_in     (tone_in),
        .tone_code   (tone_code),
        .tone_valid  (tone_valid),
        .tone_change (tone_change)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int band(input int p);
        if (p >= LIM0 && p <= LIM1) return 3;
        if (p >  LIM1 && p <= LIM2) return 2;
        if (p >  LIM2 && p <= LIM3) return 1;
        if (p >  LIM3 && p <  LIM4) return 0;
        return -1;
    endfunction

    task automatic model_reset();
        hist.delete();
        m_valid = 0;
        m_code = 0;
        last_edge = cyc - 1_000_000;
    endtask

    // Called at every pin rising edge; gap is cycles since the previous edge.
    task automatic model_edge();
        int gap;
        int c;
        bit same;
        gap = cyc - last_edge;
        last_edge = cyc;
        exp_chg_now = 0;
        if (gap > LIM4) begin
            hist.delete();
            m_valid = 0;
            return;
        end
        c = band(gap);
        if (c < 0) begin
            hist.delete();
            m_valid = 0;
            return;
        end
        hist.push_back(c);
        if (hist.size() < MATCH_N) return;
        same = 1'b1;
        for (int k = 1; k <= MATCH_N; k++)
            if (hist[hist.size() - k] != c) same = 1'b0;
        if (same && (m_valid == 0 || m_code != c)) begin
            m_code = c;
            m_valid = 1;
            exp_chg_now = 1;
        end
    endtask

    // Rising edge now; the next edge follows p cycles later.
    task automatic run_period(input int p);
        int chg;
        bit prev;
        chg = 0;
        prev = 1'b0;
        chg_pos = -1;
        @(negedge clk);
        tone_in = 1'b1;
        model_edge();
        for (int i = 1; i < p; i++) begin
            @(negedge clk);
            if (i == p / 2) tone_in = 1'b0;
            if (tone_change) begin
                chg++;
                if (chg_pos < 0) chg_pos = i;
                if (prev) check("change_width", 2, 1);
            end
            prev = tone_change;
            if (i == 6) begin
                check("valid", int'(tone_valid), m_valid);
                check("code", int'(tone_code), m_code);
            end
        end
        check("change_count", chg, exp_chg_now);
        win_chg = chg;
    endtask

    task automatic silence(input int n);
        int chg;
        chg = 0;
        tone_in = 1'b0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (tone_change) chg++;
        end
        check("silence_change", chg, 0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            tone_in = ~tone_in;
            check("rst_code", int'(tone_code), 0);
            check("rst_valid", int'(tone_valid), 0);
            check("rst_change", int'(tone_change), 0);
        end
        tone_in = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        repeat (3) @(negedge clk);
        check("arm_after_reset", int'(dut.state), int'(ST_ARM));
        check("valid_after_reset", int'(tone_valid), 0);
    endtask

    initial begin
        int drop_at;
        int base;
        int n;
        int nominal[4];

        nominal[0] = 96; nominal[1] = 120; nominal[2] = 152; nominal[3] = 192;

        vecs[0]  = '{96,  3, 1, 3};
        vecs[1]  = '{108, 3, 1, 3};
        vecs[2]  = '{109, 3, 1, 2};
        vecs[3]  = '{87,  3, 0, 2};
        vecs[4]  = '{88,  3, 1, 3};
        vecs[5]  = '{135, 3, 1, 2};
        vecs[6]  = '{136, 3, 1, 1};
        vecs[7]  = '{171, 3, 1, 1};
        vecs[8]  = '{172, 3, 1, 0};
        vecs[9]  = '{209, 3, 1, 0};
        vecs[10] = '{210, 3, 0, 0};
        vecs[11] = '{152, 2, 0, 0};
        vecs[12] = '{120, 3, 1, 2};

        do_reset();

        // Band boundaries and basic locks: arming edge + reps periods each
        for (int v = 0; v < 13; v++) begin
            silence(LIM4 + 20);
            for (int k = 0; k <= vecs[v].reps; k++) run_period(vecs[v].period);
            check($sformatf("vec%0d_valid", v), int'(tone_valid), vecs[v].exp_valid);
            check($sformatf("vec%0d_code", v), int'(tone_code), vecs[v].exp_code);
        end

        // Lock 523 Hz, then move to 261 Hz
        silence(LIM4 + 20);
        repeat (3) run_period(96);
        run_period(192);
        check("lock523_valid", int'(tone_valid), 1);
        check("lock523_code", int'(tone_code), 3);
        check("lock523_pulse", win_chg, 1);
        check("lock523_latency", int'(chg_pos >= 3 && chg_pos <= 4), 1);
        run_period(192);
        check("chg1_valid", int'(tone_valid), 1);
        check("chg1_code", int'(tone_code), 3);
        run_period(192);
        check("chg2_code", int'(tone_code), 3);
        run_period(192);
        check("chg3_code", int'(tone_code), 0);
        check("chg3_pulse", win_chg, 1);

        // Out-of-band glitch while locked at 415 Hz
        silence(LIM4 + 20);
        repeat (3) run_period(120);
        run_period(60);
        run_period(120);
        check("oob_valid", int'(tone_valid), 0);
        check("oob_code", int'(tone_code), 2);
        repeat (2) run_period(120);
        run_period(120);
        check("relock_valid", int'(tone_valid), 1);
        check("relock_code", int'(tone_code), 2);
        check("relock_pulse", win_chg, 1);

        // Timeout while locked at 329 Hz
        silence(LIM4 + 20);
        repeat (4) run_period(152);
        check("to_locked", int'(tone_valid), 1);
        drop_at = -1;
        for (int j = 152; j <= 400; j++) begin
            @(negedge clk);
            if (!tone_valid) begin
                drop_at = j;
                break;
            end
        end
        check("timeout_drop_cycle", drop_at, OUT_LAT + LIM4);
        repeat (3) run_period(152);
        check("restart_not_yet", int'(tone_valid), 0);
        run_period(152);
        check("restart_valid", int'(tone_valid), 1);
        check("restart_code", int'(tone_code), 1);
        check("restart_pulse", win_chg, 1);

        // Reset in the middle of a measurement
        silence(LIM4 + 20);
        repeat (2) run_period(96);
        do_reset();
        repeat (3) run_period(96);
        check("post_rst_arm_only", int'(tone_valid), 0);
        run_period(96);
        check("post_rst_lock", int'(tone_valid), 1);
        check("post_rst_code", int'(tone_code), 3);

        // Randomized bursts against the model
        silence(LIM4 + 20);
        for (int r = 0; r < 30; r++) begin
            if ($urandom_range(0, 1) == 1) base = nominal[$urandom_range(0, 3)];
            else base = int'($urandom_range(50, 230));
            n = int'($urandom_range(1, 4));
            for (int k = 0; k < n; k++) run_period(base);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/tone_detector.md
# tone_detector

Receive-side counterpart to the buzzer tone generator. Samples an asynchronous square-wave input, measures its period in system-clock cycles, and decodes it to the same 2-bit tone code the generator is driven by (00 = 261 Hz, 01 = 329 Hz, 10 = 415 Hz, 11 = 523 Hz). Sits at the board input pin, feeding the game/state logic with a debounced, locked tone code.

## Interface

- CLK_HZ, 50_000_000: system clock frequency; documentation only, limits below are in cycles at this rate.
- CNT_W, 18: period counter width; must hold LIM4.
- LIM0, 88_000: minimum legal period (cycles).
- LIM1, 108_000: upper bound of the 523 Hz band (nominal 95_602).
- LIM2, 135_000: upper bound of the 415 Hz band (nominal 120_482).
- LIM3, 171_000: upper bound of the 329 Hz band (nominal 151_976).
- LIM4, 210_000: upper bound of the 261 Hz band (nominal 191_571), and the timeout.
- MATCH_N, 3: consecutive same-band periods required to lock or change code.

Ports:
- clk  in  1  system clock; all logic on its rising edge.
- rst_n  in  1  synchronous, active-low reset.
- tone_in  in  1  asynchronous square wave from the pin.
- tone_code  out  2  locked tone code; reset 2'b00.
- tone_valid  out  1  high while a tone is locked; reset 0.
- tone_change  out  1  one-cycle pulse when tone_code is loaded or changes; reset 0.

## Operation

- tone_in passes through a 2-flop synchronizer, then a third flop for rising-edge detection, producing `rise` (1-cycle pulse).
- FSM states:
  - ARM (reset state): counter held at 0; on `rise` go to MEASURE, counter := 0.
  - MEASURE: counter increments each cycle, saturating at LIM4.
    - On `rise`: period P = counter + 1; classify; counter := 0; stay in MEASURE.
    - If the counter reaches LIM4 with no `rise` (timeout): go to ARM, clear tone_valid and the match count.
- Classification of P:
  - LIM0 ≤ P ≤ LIM1 → 11
  - LIM1 < P ≤ LIM2 → 10
  - LIM2 < P ≤ LIM3 → 01
  - LIM3 < P < LIM4 → 00
  - Any other P → out of band.
- Lock logic holds the registers cand[1:0] and match count mcnt (saturates at MATCH_N).
  - Out-of-band P: tone_valid := 0, mcnt := 0; tone_code holds its last value.
  - In-band P equal to cand: mcnt := mcnt + 1. Otherwise cand := class, mcnt := 1.
  - When mcnt reaches MATCH_N (including MATCH_N = 1) and either tone_valid = 0 or cand ≠ tone_code:
    - tone_code := cand
    - tone_valid := 1
    - tone_change pulses.
  - A different in-band class does not drop tone_valid; the old code stays until the new class has MATCH_N matches.
- Reset mid-measurement: all state returns to reset values; the next `rise` only arms the FSM and measures nothing.

## Timing

- A tone_in rising edge produces `rise` 3 clk cycles after the edge is first sampled high.
- tone_code, tone_valid and tone_change update on the clk edge that ends the `rise` cycle. Latency from a pin edge to the outputs is 3 cycles plus synchronizer uncertainty (0–1 cycle).
- Lock from silence: the first `rise` arms the FSM, then MATCH_N periods follow. Lock occurs at the (MATCH_N+1)-th rising edge.
- Timeout drop: tone_valid falls on the cycle the counter reaches LIM4, i.e. LIM4 cycles after the last `rise`.
- tone_change is never high for two consecutive cycles.
- `rise` and timeout never coincide: `rise` takes priority and the counter resets.

## Structure

- Shared package tone_pkg holds:
  - the tone code constants TONE_261 = 2'b00, TONE_329 = 2'b01, TONE_415 = 2'b10, TONE_523 = 2'b11, which the buzzer generator also uses;
  - default LIM0–LIM4 for 50 MHz;
  - the FSM state encoding.
- One sub-module, sync_edge: 2-flop synchronizer plus rising-edge pulse, with rst_n. It is reusable by the other synchronizer exercises.

## Test plan

- Reset: hold rst_n = 0 for 5 cycles while tone_in toggles → tone_code = 00, tone_valid = 0, tone_change = 0 throughout; FSM is in ARM after release.
- Lock 523 Hz: drive period 95_602 cycles, 4 rising edges → tone_valid rises with tone_code = 11 and a single tone_change pulse 3–4 cycles after the 4th edge.
- Change 523 → 261 Hz (191_571 cycles):
  - tone_valid stays 1 and tone_code stays 11 through 2 periods;
  - after the 3rd long period, tone_code = 00 with one tone_change pulse.
- Out-of-band: while locked at 415 Hz, inject one period of 60_000 cycles → tone_valid = 0 and tone_code holds 10. Three further 120_482-cycle periods re-lock with a tone_change pulse.
- Timeout: stop tone_in while locked at 329 Hz → tone_valid falls exactly 210_000 cycles after the last `rise`. Restarting needs 1 arming edge plus 3 periods.
- Band boundaries: periods of 108_000 → class 11, 108_001 → class 10, 87_999 → out of band, 210_000 → timeout. Each is checked after MATCH_N repeats.
